// File: rtl/reset_sequencer.sv
// Multi-channel reset generator: synchronised release, stretch, then staggered channel releases.
// Define RSTSEQ_SOFT_RESET_EN to build the glitch-filtered soft-reset path (filter + HOLD state).
module reset_sequencer #(
    parameter int NUM_CHANNELS   = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int STRETCH_CYCLES = 16,
    parameter int STAGGER_CYCLES = 4,
    parameter int FILTER_CYCLES  = 3
) (
    input  logic                    clock,
    input  logic                    resetIn,
    input  logic                    softResetReq,
    output logic [NUM_CHANNELS-1:0] resetOut,
    output logic                    resetDone
);

    localparam int CNT_MAX = (STRETCH_CYCLES > STAGGER_CYCLES) ? STRETCH_CYCLES : STAGGER_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int CH_W    = $clog2(NUM_CHANNELS + 1);

    typedef enum logic [2:0] {
        WAIT_SYNC,
        STRETCH,
        RELEASE,
        DONE,
        HOLD
    } stateT;

    stateT                   stateReg, stateNext;
    logic [CNT_W-1:0]        cntReg, cntNext;
    logic [CH_W-1:0]         chReg, chNext;
    logic [NUM_CHANNELS-1:0] resetOutReg, resetOutNext;
    logic                    doneReg, doneNext;
    logic [SYNC_STAGES-1:0]  syncReg;
    logic                    synced;
    logic [NUM_CHANNELS-1:0] releaseHit;

`ifdef RSTSEQ_SOFT_RESET_EN
    localparam int FCNT_W = $clog2(FILTER_CYCLES + 1);

    logic [FCNT_W-1:0] fcntReg, fcntNext;
    logic              softAccept;
`else
    localparam int unusedFilterCycles = FILTER_CYCLES;

    logic unusedSoftReq;
    assign unusedSoftReq = softResetReq;
`endif

    // Release synchroniser: assertion is immediate, release ripples through SYNC_STAGES flops.
    always_ff @(posedge clock or negedge resetIn) begin
        if (!resetIn) begin
            syncReg <= '0;
        end else begin
            syncReg <= {syncReg[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign synced = syncReg[SYNC_STAGES-1];

    generate
        for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : gReleaseHit
            assign releaseHit[gi] = (chReg == CH_W'(gi));
        end
    endgenerate

    always_ff @(posedge clock or negedge resetIn) begin
        if (!resetIn) begin
            stateReg    <= WAIT_SYNC;
            cntReg      <= '0;
            chReg       <= '0;
            resetOutReg <= '1;
            doneReg     <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            cntReg      <= cntNext;
            chReg       <= chNext;
            resetOutReg <= resetOutNext;
            doneReg     <= doneNext;
        end
    end

`ifdef RSTSEQ_SOFT_RESET_EN
    always_ff @(posedge clock or negedge resetIn) begin
        if (!resetIn) begin
            fcntReg <= '0;
        end else begin
            fcntReg <= fcntNext;
        end
    end

    // Filter counts consecutive high samples; it is parked at zero until the synchroniser releases.
    always_comb begin
        fcntNext = fcntReg;
        if (stateReg == WAIT_SYNC || !softResetReq) begin
            fcntNext = '0;
        end else if (fcntReg != FCNT_W'(FILTER_CYCLES)) begin
            fcntNext = fcntReg + 1'b1;
        end
    end

    assign softAccept = softResetReq
                     && (fcntReg == FCNT_W'(FILTER_CYCLES - 1))
                     && (stateReg inside {STRETCH, RELEASE, DONE});
`endif

    always_comb begin
        stateNext    = stateReg;
        cntNext      = cntReg;
        chNext       = chReg;
        resetOutNext = resetOutReg;
        doneNext     = doneReg;

        case (stateReg)
            WAIT_SYNC: begin
                if (synced) begin
                    stateNext = STRETCH;
                    cntNext   = '0;
                end
            end
            STRETCH: begin
                if (cntReg == CNT_W'(STRETCH_CYCLES - 1)) begin
                    resetOutNext[0] = 1'b0;
                    stateNext       = RELEASE;
                    chNext          = CH_W'(1);
                    cntNext         = '0;
                end else begin
                    cntNext = cntReg + 1'b1;
                end
            end
            RELEASE: begin
                // chReg == NUM_CHANNELS means every channel is already released.
                if (chReg == CH_W'(NUM_CHANNELS)) begin
                    stateNext = DONE;
                    doneNext  = 1'b1;
                    cntNext   = '0;
                end else if (cntReg == CNT_W'(STAGGER_CYCLES - 1)) begin
                    resetOutNext = resetOutReg & ~releaseHit;
                    chNext       = chReg + 1'b1;
                    cntNext      = '0;
                end else begin
                    cntNext = cntReg + 1'b1;
                end
            end
            DONE: begin
                doneNext = 1'b1;
            end
`ifdef RSTSEQ_SOFT_RESET_EN
            HOLD: begin
                resetOutNext = '1;
                doneNext     = 1'b0;
                if (!softResetReq) begin
                    stateNext = STRETCH;
                    cntNext   = '0;
                    chNext    = '0;
                end
            end
`endif
            default: begin
                stateNext    = WAIT_SYNC;
                cntNext      = '0;
                chNext       = '0;
                resetOutNext = '1;
                doneNext     = 1'b0;
            end
        endcase

`ifdef RSTSEQ_SOFT_RESET_EN
        // An accepted soft request overrides whatever the sequence was about to do this edge.
        if (softAccept) begin
            stateNext    = HOLD;
            resetOutNext = '1;
            doneNext     = 1'b0;
            cntNext      = '0;
            chNext       = '0;
        end
`endif
    end

    assign resetOut  = resetOutReg;
    assign resetDone = doneReg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed timing checks plus random reset/soft-request traffic,
// with two instances (default and minimal parameters) compared against a timeline model.
module tb_reset_sequencer;

`ifdef RSTSEQ_SOFT_RESET_EN
    localparam bit SOFT_EN = 1'b1;
`else
    localparam bit SOFT_EN = 1'b0;
`endif
    localparam int FILT = 3;

    logic       clock;
    logic       resetIn;
    logic       softResetReq;
    logic [3:0] resetOut0;
    logic       resetDone0;
    logic [0:0] resetOut1;
    logic       resetDone1;

    reset_sequencer #(
        .NUM_CHANNELS(4), .SYNC_STAGES(2), .STRETCH_CYCLES(16),
        .STAGGER_CYCLES(4), .FILTER_CYCLES(FILT)
    ) dut0 (
        .clock(clock), .resetIn(resetIn), .softResetReq(softResetReq),
        .resetOut(resetOut0), .resetDone(resetDone0)
    );

    reset_sequencer #(
        .NUM_CHANNELS(1), .SYNC_STAGES(3), .STRETCH_CYCLES(1),
        .STAGGER_CYCLES(1), .FILTER_CYCLES(FILT)
    ) dut1 (
        .clock(clock), .resetIn(resetIn), .softResetReq(softResetReq),
        .resetOut(resetOut1), .resetDone(resetDone1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int vectorCount = 0;
    int missCount   = 0;

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("FAIL %s: observed %0h expected %0h at t=%0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int pN(input int j);       return (j == 0) ? 4  : 1; endfunction
    function automatic int pSync(input int j);    return (j == 0) ? 2  : 3; endfunction
    function automatic int pStretch(input int j); return (j == 0) ? 16 : 1; endfunction
    function automatic int pStagger(input int j); return (j == 0) ? 4  : 1; endfunction

    // Timeline model: edgeNum is the index of the last edge since resetIn release (E1 = 1);
    // mSeqStart is the edge that entered the stretch phase; every release time follows from it.
    int edgeNum = 0;
    int mSeqStart [2];
    bit mHold [2];
    int mRun [2];

    initial begin
        for (int j = 0; j < 2; j++) begin
            mSeqStart[j] = pSync(j) + 1;
            mHold[j]     = 1'b0;
            mRun[j]      = 0;
        end
        forever begin
            @(posedge clock or negedge resetIn);
            if (!resetIn) begin
                edgeNum = 0;
                for (int j = 0; j < 2; j++) begin
                    mSeqStart[j] = pSync(j) + 1;
                    mHold[j]     = 1'b0;
                    mRun[j]      = 0;
                end
            end else begin
                edgeNum = edgeNum + 1;
                if (SOFT_EN) begin
                    for (int j = 0; j < 2; j++) begin
                        if (mHold[j]) begin
                            if (softResetReq) begin
                                mRun[j] = mRun[j] + 1;
                            end else begin
                                mHold[j]     = 1'b0;
                                mSeqStart[j] = edgeNum;
                                mRun[j]      = 0;
                            end
                        end else if (softResetReq && edgeNum > mSeqStart[j]) begin
                            mRun[j] = mRun[j] + 1;
                            if (mRun[j] == FILT) mHold[j] = 1'b1;
                        end else begin
                            mRun[j] = 0;
                        end
                    end
                end
            end
        end
    end

    function automatic logic [3:0] expOut(input int j);
        logic [3:0] e;
        e = '0;
        for (int i = 0; i < pN(j); i++) begin
            e[i] = !(resetIn && !mHold[j] &&
                     edgeNum >= mSeqStart[j] + pStretch(j) + i * pStagger(j));
        end
        return e;
    endfunction

    function automatic logic expDone(input int j);
        return resetIn && !mHold[j] &&
               edgeNum >= mSeqStart[j] + pStretch(j) + (pN(j) - 1) * pStagger(j) + 1;
    endfunction

    initial begin
        forever begin
            @(negedge clock);
            #2;
            checkValue("m_out4",  32'(resetOut0),  32'(expOut(0)));
            checkValue("m_done4", 32'(resetDone0), 32'(expDone(0)));
            checkValue("m_out1",  32'(resetOut1),  32'(expOut(1)));
            checkValue("m_done1", 32'(resetDone1), 32'(expDone(1)));
        end
    end

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clock);
        @(negedge clock);
    endtask

    task automatic pulseReset(input int lowCycles);
        @(negedge clock);
        resetIn = 1'b0;
        repeat (lowCycles) @(negedge clock);
        resetIn = 1'b1;
    endtask

    task automatic asyncGlitch(input string tag);
        @(posedge clock);
        #1 resetIn = 1'b0;
        #1;
        checkValue({tag, "_out4"},  32'(resetOut0),  32'hF);
        checkValue({tag, "_out1"},  32'(resetOut1),  32'h1);
        checkValue({tag, "_done4"}, 32'(resetDone0), 32'h0);
        #1 resetIn = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        int op;
        int len;
        resetIn      = 1'b0;
        softResetReq = 1'b0;

        #100;
        @(negedge clock);
        checkValue("pu_hold_out4", 32'(resetOut0), 32'hF);
        checkValue("pu_hold_out1", 32'(resetOut1), 32'h1);
        resetIn = 1'b1;
        $display("[%0t] power-up: resetIn released", $time);

        waitEdges(4);  checkValue("sw_e4_out",  32'(resetOut1),  32'h1);
        waitEdges(1);  checkValue("sw_e5_out",  32'(resetOut1),  32'h0);
                       checkValue("sw_e5_done", 32'(resetDone1), 32'h0);
        waitEdges(1);  checkValue("sw_e6_done", 32'(resetDone1), 32'h1);
        waitEdges(12); checkValue("pu_e18",     32'(resetOut0),  32'hF);
        waitEdges(1);  checkValue("pu_e19",     32'(resetOut0),  32'hE);
        waitEdges(4);  checkValue("pu_e23",     32'(resetOut0),  32'hC);
        waitEdges(4);  checkValue("pu_e27",     32'(resetOut0),  32'h8);
        waitEdges(4);  checkValue("pu_e31",     32'(resetOut0),  32'h0);
                       checkValue("pu_e31_done", 32'(resetDone0), 32'h0);
        waitEdges(1);  checkValue("pu_e32_done", 32'(resetDone0), 32'h1);
        $display("[%0t] power-up sequence complete", $time);

        pulseReset(2);
        waitEdges(9);
        asyncGlitch("gl_e10");
        waitEdges(18); checkValue("gl_e18", 32'(resetOut0), 32'hF);
        waitEdges(1);  checkValue("gl_e19", 32'(resetOut0), 32'hE);
        waitEdges(13); checkValue("gl_e32_done", 32'(resetDone0), 32'h1);
        $display("[%0t] release glitch at E10: sequence restarted", $time);

        softResetReq = 1'b1;
        waitEdges(2);
        softResetReq = 1'b0;
        waitEdges(3);
        checkValue("sg_done", 32'(resetDone0), 32'h1);
        checkValue("sg_out",  32'(resetOut0),  32'h0);
        $display("[%0t] soft pulse of 2 cycles applied in DONE", $time);

        softResetReq = 1'b1;
        waitEdges(2);  checkValue("sa_h1",   32'(resetOut0),  32'h0);
        waitEdges(1);  checkValue("sa_h2",   32'(resetOut0),  SOFT_EN ? 32'hF : 32'h0);
                       checkValue("sa_h2_done", 32'(resetDone0), SOFT_EN ? 32'h0 : 32'h1);
        waitEdges(7);
        softResetReq = 1'b0;
        waitEdges(15); checkValue("sa_l15",  32'(resetOut0),  SOFT_EN ? 32'hF : 32'h0);
        waitEdges(1);  checkValue("sa_l16",  32'(resetOut0),  SOFT_EN ? 32'hE : 32'h0);
        waitEdges(12); checkValue("sa_l28",  32'(resetOut0),  32'h0);
                       checkValue("sa_l28_done", 32'(resetDone0), SOFT_EN ? 32'h0 : 32'h1);
        waitEdges(1);  checkValue("sa_l29_done", 32'(resetDone0), 32'h1);
        $display("[%0t] soft request held 10 cycles in DONE", $time);

        pulseReset(2);
        waitEdges(20);
        softResetReq = 1'b1;
        waitEdges(3);  checkValue("sm_e23", 32'(resetOut0), SOFT_EN ? 32'hF : 32'hC);
        waitEdges(1);
        softResetReq = 1'b0;
        waitEdges(45);
        $display("[%0t] soft request mid-sequence (channel 1 still held)", $time);

        for (int it = 0; it < 80; it++) begin
            op = int'($urandom_range(0, 9));
            if (op == 0) begin
                len = int'($urandom_range(1, 3));
                pulseReset(len);
                $display("[%0t] random: resetIn low for %0d cycles", $time, len);
            end else if (op == 1) begin
                asyncGlitch("rg");
                $display("[%0t] random: async resetIn glitch", $time);
            end else if (op <= 6) begin
                len = int'($urandom_range(1, 6));
                @(negedge clock);
                softResetReq = 1'b1;
                repeat (len) @(negedge clock);
                softResetReq = 1'b0;
                $display("[%0t] random: soft request for %0d cycles", $time, len);
            end else begin
                len = int'($urandom_range(1, 40));
                repeat (len) @(negedge clock);
                $display("[%0t] random: idle %0d cycles", $time, len);
            end
        end

        softResetReq = 1'b0;
        waitEdges(60);
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
